// File: rtl/seg7_pkg.sv
// Shared types, segment patterns and the hex-to-segment encoder used by the
// 7-segment scan driver. Patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // All segments dark.
  localparam seg_t SEG_BLANK = 7'h7F;

  // Hex glyphs 0..F (lower-case b and d keep them distinct from 8 and 0).
  localparam seg_t SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h58,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Map one nibble to its active-low segment pattern.
  function automatic seg_t seg_encode(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/seg7_lzb_mask.sv
// Leading-zero blanking mask. A digit is blanked when blanking is enabled
// and that digit together with every more significant digit is zero.
// The least significant digit is never blanked so a zero word shows "0".
module seg7_lzb_mask #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] word,
  input  logic                    lzb,
  output logic [NUM_DIGITS-1:0]   blank
);

  // zero_from[i] = nibble i and all higher nibbles are zero
  logic [NUM_DIGITS-1:0] zero_from;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
      assign zero_from[gi] = (word[4*NUM_DIGITS-1:4*gi] == '0);
    end
  endgenerate

  // Digit 0 is masked out of the blank vector unconditionally.
  assign blank = {NUM_DIGITS{lzb}} & zero_from & ~NUM_DIGITS'(1);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for common-anode 7-segment digits on a shared
// segment bus. A new display word is accepted over valid/ready into a
// pending buffer and only copied to the visible word at a frame boundary,
// so one frame never mixes two words. Each digit slot starts with one
// all-off cycle (anti-ghosting) while the segment bus settles.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    load_lzb,
  input  logic [NUM_DIGITS-1:0]   load_blink,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel_n
);

  import seg7_pkg::*;

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  // Scan and blink timing state
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [BLK_W-1:0] blk_cnt_reg, blk_cnt_next;
  logic             blink_on_reg, blink_on_next;
  logic             cnt_term, blk_term, frame_bnd;

  // Visible and pending display words
  logic [4*NUM_DIGITS-1:0] disp_reg, disp_next;
  logic                    lzb_reg, lzb_next;
  logic [NUM_DIGITS-1:0]   blink_reg, blink_next;
  logic [4*NUM_DIGITS-1:0] pend_data_reg;
  logic                    pend_lzb_reg;
  logic [NUM_DIGITS-1:0]   pend_blink_reg;
  logic                    pend_flag_reg;
  logic                    transfer, commit;

  // Output registers and the pattern feeding them
  seg_t                  seg_reg, seg_next, pattern;
  logic [NUM_DIGITS-1:0] dig_sel_n_reg, dig_next;
  logic [NUM_DIGITS-1:0] lzb_blank;
  logic [3:0]            nib_arr [NUM_DIGITS];

  // The pending buffer holds at most one word, so ready is simply "empty".
  assign load_ready = ~pend_flag_reg;
  assign transfer   = load_valid & load_ready;

  // Timing next-state: slot counter, digit index and blink phase
  always_comb begin
    cnt_term      = (cnt_reg == CNT_LAST);
    cnt_next      = cnt_term ? '0 : cnt_reg + 1'b1;
    idx_next      = idx_reg;
    if (cnt_term) begin
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end
    frame_bnd     = cnt_term && (idx_reg == IDX_LAST);
    blk_term      = (blk_cnt_reg == BLK_LAST);
    blk_cnt_next  = blk_term ? '0 : blk_cnt_reg + 1'b1;
    blink_on_next = blk_term ? ~blink_on_reg : blink_on_reg;
  end

  // Pending word becomes visible only on the frame-boundary edge.
  always_comb begin
    commit     = frame_bnd && pend_flag_reg;
    disp_next  = commit ? pend_data_reg  : disp_reg;
    lzb_next   = commit ? pend_lzb_reg   : lzb_reg;
    blink_next = commit ? pend_blink_reg : blink_reg;
  end

  // Blank mask is taken from the word that will be visible next cycle, so
  // the first slot of a new frame already reflects the committed word.
  seg7_lzb_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lzb_mask (
    .word  (disp_next),
    .lzb   (lzb_next),
    .blank (lzb_blank)
  );

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nib_arr[gi] = disp_next[4*gi +: 4];
    end
  endgenerate

  // Segment pattern for the upcoming slot; LZ blanking wins over blink.
  always_comb begin
    pattern = seg_encode(nib_arr[idx_next]);
    if (lzb_blank[idx_next]) begin
      pattern = SEG_BLANK;
    end else if (blink_next[idx_next] && !blink_on_next) begin
      pattern = SEG_BLANK;
    end
    // seg only changes on the edge that starts a slot (dead-time cycle)
    seg_next = cnt_term ? pattern : seg_reg;
    // All enables off in the first cycle of every slot.
    dig_next = '1;
    if (cnt_next != '0) begin
      dig_next[idx_next] = 1'b0;
    end
  end

  // Refresh and blink counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg      <= '0;
      idx_reg      <= '0;
      blk_cnt_reg  <= '0;
      blink_on_reg <= 1'b1;
    end else begin
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      blk_cnt_reg  <= blk_cnt_next;
      blink_on_reg <= blink_on_next;
    end
  end

  // Handshake capture into pending and frame-boundary commit to display
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_data_reg  <= '0;
      pend_lzb_reg   <= 1'b0;
      pend_blink_reg <= '0;
      pend_flag_reg  <= 1'b0;
      disp_reg       <= '0;
      lzb_reg        <= 1'b0;
      blink_reg      <= '0;
    end else begin
      if (transfer) begin
        pend_data_reg  <= load_data;
        pend_lzb_reg   <= load_lzb;
        pend_blink_reg <= load_blink;
        pend_flag_reg  <= 1'b1;
      end else if (commit) begin
        pend_flag_reg  <= 1'b0;
      end
      disp_reg  <= disp_next;
      lzb_reg   <= lzb_next;
      blink_reg <= blink_next;
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_reg       <= SEG_BLANK;
      dig_sel_n_reg <= '1;
    end else begin
      seg_reg       <= seg_next;
      dig_sel_n_reg <= dig_next;
    end
  end

  assign seg       = seg_reg;
  assign dig_sel_n = dig_sel_n_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 4-cycle slots and a
// 40-cycle blink half-period. The bench counts clock edges since reset
// release in n, so every slot and frame position is known without looking
// at the DUT: slot start when n%4==0, frame start when n%16==0.
module tb_seg7_scan_driver;

  logic        clk;
  logic        reset_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        load_lzb;
  logic [3:0]  load_blink;
  logic [6:0]  seg;
  logic [3:0]  dig_sel_n;

  int tests_run;
  int tests_failed;
  int n;

  logic [3:0] exp_dig_tbl [16];
  logic [3:0] dig_on_tbl  [4];
  logic [6:0] a_exp       [4];
  logic [6:0] exp2;

  seg7_scan_driver #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLINK_DIV   (40)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_lzb   (load_lzb),
    .load_blink (load_blink),
    .seg        (seg),
    .dig_sel_n  (dig_sel_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s (n=%0d): got %0h, expected %0h", tag, n, got, exp);
    end
  endtask

  // Advance one clock edge; sample/drive 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
    n++;
  endtask

  // Check one whole frame starting at n%16==0 against four expected glyphs.
  task automatic check_frame(input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int d = 0; d < 4; d++) begin
      check_val("slot_seg_dead", 16'(seg), 16'(e[d]));
      check_val("slot_dig_dead", 16'(dig_sel_n), 16'h000F);
      cycle();
      check_val("slot_dig_on", 16'(dig_sel_n), 16'(dig_on_tbl[d]));
      check_val("slot_seg_on", 16'(seg), 16'(e[d]));
      cycle();
      cycle();
      cycle();
    end
  endtask

  // Offer one word at a frame start and follow it through to its commit.
  task automatic do_load(input logic [15:0] d, input logic lzb, input logic [3:0] bl);
    $display("[TB] load data=%h lzb=%0b blink=%b at n=%0d", d, lzb, bl, n);
    load_data  = d;
    load_lzb   = lzb;
    load_blink = bl;
    load_valid = 1'b1;
    check_val("ready_before_load", 16'(load_ready), 16'h1);
    cycle();
    load_valid = 1'b0;
    load_data  = 16'hDEAD;
    load_lzb   = 1'b0;
    load_blink = 4'hF;
    check_val("ready_low_after_load", 16'(load_ready), 16'h0);
    while ((n % 16) != 15) cycle();
    check_val("ready_low_at_boundary", 16'(load_ready), 16'h0);
    cycle();
    check_val("ready_high_after_commit", 16'(load_ready), 16'h1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    n            = 0;
    exp_dig_tbl = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                    4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
    dig_on_tbl  = '{4'hE, 4'hD, 4'hB, 4'h7};
    a_exp       = '{7'h02, 7'h12, 7'h19, 7'h30};

    reset_n    = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    load_lzb   = 1'b0;
    load_blink = 4'h0;

    // 1: reset values, then the scan sequence with one dead cycle per slot
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_seg", 16'(seg), 16'h007F);
    check_val("rst_dig", 16'(dig_sel_n), 16'h000F);
    check_val("rst_ready", 16'(load_ready), 16'h1);
    #2 reset_n = 1'b1;
    n = 0;
    check_val("rel_seg", 16'(seg), 16'h007F);
    check_val("rel_dig", 16'(dig_sel_n), 16'h000F);
    for (int k = 1; k <= 16; k++) begin
      cycle();
      check_val("scan_dig", 16'(dig_sel_n), 16'(exp_dig_tbl[k-1]));
      if (k == 4) check_val("scan_seg_zero", 16'(seg), 16'h0040);
    end
    $display("[TB] scan sequence checked, n=%0d", n);

    // 2: plain hex word
    do_load(16'h12AF, 1'b0, 4'b0000);
    check_frame(7'h0E, 7'h08, 7'h24, 7'h79);

    // 3: leading-zero blanking
    do_load(16'h0070, 1'b1, 4'b0000);
    check_frame(7'h40, 7'h58, 7'h7F, 7'h7F);
    do_load(16'h0000, 1'b1, 4'b0000);
    check_frame(7'h40, 7'h7F, 7'h7F, 7'h7F);

    // 4: blink on digit 2; phase is on when (n/40) is even
    do_load(16'h8888, 1'b0, 4'b0100);
    for (int f = 0; f < 8; f++) begin
      exp2 = (((n + 8) / 40) % 2 == 0) ? 7'h00 : 7'h7F;
      $display("[TB] blink frame n=%0d digit2 expect %h", n, exp2);
      check_frame(7'h00, 7'h00, exp2, 7'h00);
    end

    // 5: back-to-back loads, B held valid while A is pending
    $display("[TB] load A=3456 then B=9ABC at n=%0d", n);
    load_data  = 16'h3456;
    load_lzb   = 1'b0;
    load_blink = 4'h0;
    load_valid = 1'b1;
    check_val("a_ready", 16'(load_ready), 16'h1);
    cycle();
    load_data = 16'h9ABC;
    check_val("a_taken", 16'(load_ready), 16'h0);
    while (n < 272) begin
      cycle();
      if (n < 272) check_val("b_refused", 16'(load_ready), 16'h0);
    end
    check_val("a_committed_ready", 16'(load_ready), 16'h1);
    while (n < 288) begin
      if ((n % 4) == 0) check_val("a_frame_seg", 16'(seg), 16'(a_exp[(n - 272) / 4]));
      cycle();
      if (n == 273) begin
        load_valid = 1'b0;
        load_data  = 16'h0000;
        check_val("b_taken", 16'(load_ready), 16'h0);
      end
    end
    check_val("b_committed_ready", 16'(load_ready), 16'h1);
    check_frame(7'h46, 7'h03, 7'h08, 7'h10);

    // 6: async reset mid-slot with a load pending
    $display("[TB] load 1111 then async reset at n=%0d", n);
    load_data  = 16'h1111;
    load_valid = 1'b1;
    cycle();
    load_valid = 1'b0;
    check_val("pre_rst_pending", 16'(load_ready), 16'h0);
    cycle();
    check_val("pre_rst_dig", 16'(dig_sel_n), 16'h000E);
    #3 reset_n = 1'b0;
    #1;
    check_val("async_rst_seg", 16'(seg), 16'h007F);
    check_val("async_rst_dig", 16'(dig_sel_n), 16'h000F);
    check_val("async_rst_ready", 16'(load_ready), 16'h1);
    @(posedge clk);
    #3 reset_n = 1'b1;
    n = 0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      check_val("rescan_dig", 16'(dig_sel_n), 16'(exp_dig_tbl[k-1]));
      check_val("rescan_ready", 16'(load_ready), 16'h1);
    end
    check_val("rescan_seg", 16'(seg), 16'h0040);
    while (n < 16) cycle();
    check_val("pending_dropped_seg", 16'(seg), 16'h0040);
    check_val("pending_dropped_ready", 16'(load_ready), 16'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
